// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter_if
//  Description : Bus bundle for the register-file write-back arbiter.
//                It carries the ALU and LSU write-back handshakes, the
//                issue-stage scoreboard inputs and the hazard output, the
//                register-file write port, and scoreboard status.
//                The master modport is the pipeline/environment side.
//                The slave modport is the arbiter side.
//  Ports       : alu_valid/alu_ready/alu_rd/alu_data   ALU write-back
//                lsu_valid/lsu_ready/lsu_rd/lsu_data   LSU write-back
//                issue_valid/issue_rd                  scoreboard set
//                read_Ra/read_Rb/hazard                RAW hazard query
//                write_Rd/write_data                   register-file port
//                pending/pending_cnt/spurious_wb       status
//  Revision    : 1.0  initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32
);
    logic                alu_valid;
    logic                alu_ready;
    logic [ADDR_W-1:0]   alu_rd;
    logic [DATA_W-1:0]   alu_data;
    logic                lsu_valid;
    logic                lsu_ready;
    logic [ADDR_W-1:0]   lsu_rd;
    logic [DATA_W-1:0]   lsu_data;
    logic                issue_valid;
    logic [ADDR_W-1:0]   issue_rd;
    logic [ADDR_W-1:0]   read_Ra;
    logic [ADDR_W-1:0]   read_Rb;
    logic                hazard;
    logic [ADDR_W-1:0]   write_Rd;
    logic [DATA_W-1:0]   write_data;
    logic [NUM_REGS-1:0] pending;
    logic [ADDR_W:0]     pending_cnt;
    logic                spurious_wb;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_rd, read_Ra, read_Rb,
        input  alu_ready, lsu_ready, hazard,
        input  write_Rd, write_data, pending, pending_cnt, spurious_wb
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_valid, issue_rd, read_Ra, read_Rb,
        output alu_ready, lsu_ready, hazard,
        output write_Rd, write_data, pending, pending_cnt, spurious_wb
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Write-back arbiter and scoreboard for the register file.
//                It round-robins the single write port between the ALU and
//                the LSU. It tracks destination registers with an outstanding
//                write, and flags read-after-write hazards to issue.
//  Ports       : clk  - system clock, rising-edge state updates
//                rst  - synchronous active-high reset
//                bus  - regfile_wb_arbiter_if.slave: handshakes, issue,
//                       hazard, register-file write port, scoreboard status
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32
) (
    input  wire logic            clk,
    input  wire logic            rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam logic c_SRC_ALU = 1'b0;
    localparam logic c_SRC_LSU = 1'b1;

    logic                last_grant_q, last_grant_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                spurious_q, spurious_d;
    logic [ADDR_W-1:0]   wr_rd_q, wr_rd_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;

    logic                grant_alu_w, grant_lsu_w, xfer_w;
    logic [ADDR_W-1:0]   win_rd_w;
    logic [DATA_W-1:0]   win_data_w;
    logic                issue_set_w;

    // Grants depend only on valids and the pointer, never on data.
    // Both grants are held low during reset, so no handshake completes.
    always_comb begin
        grant_alu_w = 1'b0;
        grant_lsu_w = 1'b0;
        if (!rst) begin
            if (bus.alu_valid && bus.lsu_valid) begin
                grant_alu_w = (last_grant_q == c_SRC_LSU);
                grant_lsu_w = (last_grant_q == c_SRC_ALU);
            end else begin
                grant_alu_w = bus.alu_valid;
                grant_lsu_w = bus.lsu_valid;
            end
        end
    end

    assign xfer_w      = grant_alu_w | grant_lsu_w;
    assign win_rd_w    = grant_lsu_w ? bus.lsu_rd   : bus.alu_rd;
    assign win_data_w  = grant_lsu_w ? bus.lsu_data : bus.alu_data;
    assign issue_set_w = bus.issue_valid && (bus.issue_rd != '0);

    always_comb begin
        last_grant_d = last_grant_q;
        pending_d    = pending_q;
        spurious_d   = spurious_q;
        wr_rd_d      = '0;
        wr_data_d    = '0;
        cnt_d        = '0;

        if (xfer_w) begin
            last_grant_d = grant_lsu_w;
            wr_rd_d      = win_rd_w;
            wr_data_d    = win_data_w;
            if (win_rd_w != '0) begin
                pending_d[win_rd_w] = 1'b0;
                // A write nobody is waiting for, unless issue claims it this edge.
                if (!pending_q[win_rd_w] && !(issue_set_w && bus.issue_rd == win_rd_w))
                    spurious_d = 1'b1;
            end
        end
        // The set is applied after the clear, so a new producer replaces the old one.
        if (issue_set_w)
            pending_d[bus.issue_rd] = 1'b1;
        pending_d[0] = 1'b0;

        for (int i = 0; i < NUM_REGS; i++)
            cnt_d = cnt_d + (ADDR_W+1)'(pending_d[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= c_SRC_LSU;
            pending_q    <= '0;
            cnt_q        <= '0;
            spurious_q   <= 1'b0;
            wr_rd_q      <= '0;
            wr_data_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            pending_q    <= pending_d;
            cnt_q        <= cnt_d;
            spurious_q   <= spurious_d;
            wr_rd_q      <= wr_rd_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign bus.alu_ready   = grant_alu_w;
    assign bus.lsu_ready   = grant_lsu_w;
    assign bus.write_Rd    = wr_rd_q;
    assign bus.write_data  = wr_data_q;
    assign bus.pending     = pending_q;
    assign bus.pending_cnt = cnt_q;
    assign bus.spurious_wb = spurious_q;
    // Registered scoreboard only: a write-back landing this edge still reads as a hazard.
    assign bus.hazard = ((bus.read_Ra != '0) && pending_q[bus.read_Ra]) ||
                        ((bus.read_Rb != '0) && pending_q[bus.read_Rb]);
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Directed self-checking bench for regfile_wb_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(32)) bus ();

    regfile_wb_arbiter #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
        bus.issue_valid = 0; bus.issue_rd = 0;
        bus.read_Ra = 0; bus.read_Rb = 0;
    endtask

    task automatic issue(input logic [3:0] rd);
        bus.issue_valid = 1; bus.issue_rd = rd;
        tick();
        bus.issue_valid = 0; bus.issue_rd = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.alu_valid = 1; bus.alu_rd = 3;
        rst = 1;
        #1;
        n_checks++; if (bus.alu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_alu_ready got %b want 0", bus.alu_ready); end
        tick();
        tick();
        bus.alu_valid = 0;
        rst = 0;
        #1;
        n_checks++; if (bus.pending !== 16'h0) begin n_fail++; $display("FAIL rst_pending got %h want 0000", bus.pending); end
        n_checks++; if (bus.pending_cnt !== 5'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", bus.pending_cnt); end
        n_checks++; if (bus.write_Rd !== 4'd0 || bus.write_data !== 32'h0) begin n_fail++; $display("FAIL rst_write got %h/%h want 0/0", bus.write_Rd, bus.write_data); end
        n_checks++; if (bus.spurious_wb !== 1'b0) begin n_fail++; $display("FAIL rst_spurious got %b want 0", bus.spurious_wb); end
    endtask

    task automatic test_issue_hazard();
        issue(4'd5);
        bus.read_Ra = 5;
        #1;
        n_checks++; if (bus.pending !== 16'h0020) begin n_fail++; $display("FAIL issue_pending got %h want 0020", bus.pending); end
        n_checks++; if (bus.pending_cnt !== 5'd1) begin n_fail++; $display("FAIL issue_cnt got %0d want 1", bus.pending_cnt); end
        n_checks++; if (bus.hazard !== 1'b1) begin n_fail++; $display("FAIL issue_hazard got %b want 1", bus.hazard); end
        bus.read_Ra = 0; bus.read_Rb = 5;
        #1;
        n_checks++; if (bus.hazard !== 1'b1) begin n_fail++; $display("FAIL hazard_rb got %b want 1", bus.hazard); end
        bus.read_Rb = 6;
        #1;
        n_checks++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL hazard_clean got %b want 0", bus.hazard); end
        bus.read_Ra = 5; bus.read_Rb = 0;
    endtask

    task automatic test_alu_wb();
        bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'hDEADBEEF;
        #1;
        n_checks++; if (bus.alu_ready !== 1'b1 || bus.lsu_ready !== 1'b0) begin n_fail++; $display("FAIL alu_ready got %b/%b want 1/0", bus.alu_ready, bus.lsu_ready); end
        n_checks++; if (bus.hazard !== 1'b1) begin n_fail++; $display("FAIL alu_no_bypass got %b want 1", bus.hazard); end
        tick();
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        #1;
        n_checks++; if (bus.write_Rd !== 4'd5 || bus.write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_write got %h/%h want 5/deadbeef", bus.write_Rd, bus.write_data); end
        n_checks++; if (bus.pending !== 16'h0 || bus.hazard !== 1'b0) begin n_fail++; $display("FAIL alu_clear got %h/%b want 0000/0", bus.pending, bus.hazard); end
        tick();
        n_checks++; if (bus.write_Rd !== 4'd0 || bus.write_data !== 32'h0) begin n_fail++; $display("FAIL alu_idle got %h/%h want 0/0", bus.write_Rd, bus.write_data); end
        bus.read_Ra = 0;
    endtask

    task automatic test_round_robin();
        // Expected grant sequence per cycle: 0=ALU, 1=LSU
        logic       exp_lsu [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [3:0] exp_rd  [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
        logic [4:0] exp_cnt [4] = '{5'd3, 5'd2, 5'd1, 5'd0};
        rst = 1; tick(); rst = 0;
        for (int r = 1; r <= 4; r++) issue(4'(r));
        n_checks++; if (bus.pending_cnt !== 5'd4 || bus.pending !== 16'h001E) begin n_fail++; $display("FAIL rr_start got %0d/%h want 4/001e", bus.pending_cnt, bus.pending); end
        bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_data = 32'hA1;
        bus.lsu_valid = 1; bus.lsu_rd = 2; bus.lsu_data = 32'hB2;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++; if (bus.lsu_ready !== exp_lsu[c] || bus.alu_ready !== !exp_lsu[c]) begin n_fail++; $display("FAIL rr_grant%0d got alu=%b lsu=%b want lsu=%b", c, bus.alu_ready, bus.lsu_ready, exp_lsu[c]); end
            tick();
            n_checks++; if (bus.write_Rd !== exp_rd[c] || bus.pending_cnt !== exp_cnt[c]) begin n_fail++; $display("FAIL rr_wb%0d got rd=%0d cnt=%0d want rd=%0d cnt=%0d", c, bus.write_Rd, bus.pending_cnt, exp_rd[c], exp_cnt[c]); end
            if (c == 0) begin bus.alu_rd = 3; bus.alu_data = 32'hA3; end
            if (c == 1) begin bus.lsu_rd = 4; bus.lsu_data = 32'hB4; end
            if (c == 2) begin bus.alu_rd = 1; bus.alu_data = 32'hA5; end
        end
        idle_inputs();
        n_checks++; if (bus.write_data !== 32'hB4) begin n_fail++; $display("FAIL rr_data got %h want 000000b4", bus.write_data); end
        n_checks++; if (bus.spurious_wb !== 1'b0) begin n_fail++; $display("FAIL rr_spurious got %b want 0", bus.spurious_wb); end
    endtask

    task automatic test_same_edge();
        issue(4'd7);
        bus.issue_valid = 1; bus.issue_rd = 7;
        bus.lsu_valid = 1; bus.lsu_rd = 7; bus.lsu_data = 32'h77;
        #1;
        n_checks++; if (bus.lsu_ready !== 1'b1) begin n_fail++; $display("FAIL same_ready got %b want 1", bus.lsu_ready); end
        tick();
        idle_inputs();
        n_checks++; if (bus.pending !== 16'h0080 || bus.pending_cnt !== 5'd1) begin n_fail++; $display("FAIL same_pending got %h/%0d want 0080/1", bus.pending, bus.pending_cnt); end
        n_checks++; if (bus.write_Rd !== 4'd7 || bus.spurious_wb !== 1'b0) begin n_fail++; $display("FAIL same_write got %0d/%b want 7/0", bus.write_Rd, bus.spurious_wb); end
    endtask

    task automatic test_rd0_spurious();
        bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 32'h1234;
        #1;
        n_checks++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_ready got %b want 1", bus.alu_ready); end
        tick();
        n_checks++; if (bus.write_Rd !== 4'd0 || bus.pending !== 16'h0080 || bus.spurious_wb !== 1'b0) begin n_fail++; $display("FAIL rd0_effect got rd=%0d pend=%h sp=%b want 0/0080/0", bus.write_Rd, bus.pending, bus.spurious_wb); end
        bus.alu_rd = 9; bus.alu_data = 32'h99;
        tick();
        idle_inputs();
        n_checks++; if (bus.spurious_wb !== 1'b1 || bus.write_Rd !== 4'd9) begin n_fail++; $display("FAIL spurious_set got %b/%0d want 1/9", bus.spurious_wb, bus.write_Rd); end
        tick(); tick(); tick();
        n_checks++; if (bus.spurious_wb !== 1'b1) begin n_fail++; $display("FAIL spurious_sticky got %b want 1", bus.spurious_wb); end
    endtask

    task automatic test_reset_mid();
        issue(4'd4); issue(4'd5); issue(4'd6);
        n_checks++; if (bus.pending !== 16'h00F0 || bus.pending_cnt !== 5'd4) begin n_fail++; $display("FAIL mid_pre got %h/%0d want 00f0/4", bus.pending, bus.pending_cnt); end
        bus.alu_valid = 1; bus.alu_rd = 4; bus.alu_data = 32'hAA;
        bus.lsu_valid = 1; bus.lsu_rd = 5; bus.lsu_data = 32'hBB;
        rst = 1;
        #1;
        n_checks++; if (bus.alu_ready !== 1'b0 || bus.lsu_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready got %b/%b want 0/0", bus.alu_ready, bus.lsu_ready); end
        tick();
        rst = 0;
        #1;
        n_checks++; if (bus.pending !== 16'h0 || bus.pending_cnt !== 5'd0 || bus.write_Rd !== 4'd0) begin n_fail++; $display("FAIL mid_state got %h/%0d/%0d want 0000/0/0", bus.pending, bus.pending_cnt, bus.write_Rd); end
        n_checks++; if (bus.spurious_wb !== 1'b0) begin n_fail++; $display("FAIL mid_spurious got %b want 0", bus.spurious_wb); end
        n_checks++; if (bus.alu_ready !== 1'b1 || bus.lsu_ready !== 1'b0) begin n_fail++; $display("FAIL mid_tie got %b/%b want 1/0", bus.alu_ready, bus.lsu_ready); end
        tick();
        idle_inputs();
        n_checks++; if (bus.write_Rd !== 4'd4 || bus.write_data !== 32'hAA) begin n_fail++; $display("FAIL mid_write got %0d/%h want 4/000000aa", bus.write_Rd, bus.write_data); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_issue_hazard();
        test_alu_wb();
        test_round_robin();
        test_same_edge();
        test_rd0_spurious();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-back arbiter and scoreboard for the 16x32 register file.
- Shares the register file's single write port between two producers: the ALU and the load/store unit (LSU). Uses valid/ready handshakes and round-robin arbitration.
- Tracks which destination registers have an outstanding write, and flags read-after-write hazards to the issue stage.
- Sits between the execute/memory stages and the register file's write_Rd/write_data inputs.

Parameters:
- NUM_REGS, 16, number of architectural registers; R0 is hardwired zero.
- ADDR_W, 4, register address width; must satisfy 2^ADDR_W = NUM_REGS.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU has a write-back pending.
- alu_ready  out  1  ALU write-back accepted this cycle.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- lsu_valid  in  1  LSU has a write-back pending.
- lsu_ready  out  1  LSU write-back accepted this cycle.
- lsu_rd  in  ADDR_W  LSU destination register.
- lsu_data  in  DATA_W  load data.
- issue_valid  in  1  issue stage dispatches an instruction that writes issue_rd.
- issue_rd  in  ADDR_W  destination of the issued instruction.
- read_Ra  in  ADDR_W  first source register of the instruction in issue.
- read_Rb  in  ADDR_W  second source register of the instruction in issue.
- hazard  out  1  a source of the instruction in issue has an outstanding write.
- write_Rd  out  ADDR_W  to register file write address.
- write_data  out  DATA_W  to register file write data.
- pending  out  NUM_REGS  scoreboard bitmap; bit r set means register r has an outstanding write.
- pending_cnt  out  ADDR_W+1  population count of pending.
- spurious_wb  out  1  sticky error flag.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values (applied on the first rising edge with rst=1, including mid-operation):
  - write_Rd=0, write_data=0, pending=0, pending_cnt=0, spurious_wb=0.
  - Round-robin pointer last_grant=LSU, so the ALU wins the first tie.
  - While rst=1, alu_ready=0 and lsu_ready=0; no handshake completes and no issue is recorded.
  - In-flight scoreboard state is discarded.
- Arbitration (combinational, rst=0):
  - Only one source valid: that source is granted.
  - Both valid: the source that is not last_grant is granted.
  - Neither valid: no grant.
  - ready is asserted only on the granted source, and ready never depends on data.
  - last_grant updates on every accepted handshake.
- Handshake: a transfer occurs on the rising edge where valid&&ready.
  - A source must hold valid, rd and data stable until accepted.
  - A losing source waits; round robin bounds its wait to one transfer.
- Output stage:
  - On an accepted transfer, write_Rd/write_data register the winner's rd/data.
  - On a cycle with no transfer, they register 0/0. The register file writes every falling edge and discards R0, so idle cycles are harmless.
  - Latency: accept at rising edge N; register file commits at the falling edge within cycle N; value is readable by consumers sampling at edge N+1.
- Scoreboard:
  - Set: issue_valid && issue_rd!=0 sets pending[issue_rd] at the edge.
  - Clear: an accepted transfer with rd!=0 clears pending[rd] at the same edge.
  - Same register set and cleared on the same edge: set wins (a new producer replaces the old one).
  - Issue to an already-pending register: bit stays set; the issue stage avoids write-after-write by stalling on hazard for issue_rd externally.
  - rd=0 transfers complete normally with no scoreboard change. pending[0] is always 0.
  - pending_cnt equals the popcount of pending after each edge; range 0..NUM_REGS-1.
- hazard (combinational) = (read_Ra!=0 && pending[read_Ra]) || (read_Rb!=0 && pending[read_Rb]). It reflects the registered pending only; there is no bypass.
- spurious_wb is set when a transfer with rd!=0 is accepted while pending[rd]=0 and there is no same-edge issue to rd. It stays set until rst.

Test Plan:
- Reset, then issue_valid with issue_rd=5; next cycle read_Ra=5 -> pending=0x0020, pending_cnt=1, hazard=1.
- ALU write-back rd=5, data=0xDEADBEEF (pending[5] set) -> alu_ready=1; write_Rd=5 and write_data=0xDEADBEEF next cycle; pending[5]=0, hazard=0; the following cycle write_Rd=0, write_data=0.
- alu_valid and lsu_valid held high for 4 cycles (rd=1..4 pending) -> grants alternate ALU, LSU, ALU, LSU; each source waits at most one cycle; pending_cnt goes 4,3,2,1,0.
- issue_rd=7 and an LSU write-back with rd=7 on the same edge, pending[7] previously set -> pending[7] stays 1 and pending_cnt is unchanged.
- ALU write-back with rd=0 -> accepted; write_Rd=0; pending and spurious_wb unchanged. ALU write-back with rd=9 while pending[9]=0 -> spurious_wb=1 until rst.
- rst pulsed with pending=0x00F0 and both sources valid -> readies 0 during rst; next cycle pending=0, pending_cnt=0, write_Rd=0; first tie afterwards is granted to the ALU.
